// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_pkg
// Purpose  : Shared constants and types for the bouncing-box pixel stage.
// Revision : 1.0 - initial release
// ============================================================================
package vga_pkg;

  // Default visible raster and counter width of hvsync_generator
  localparam int c_H_ACTIVE = 640;
  localparam int c_V_ACTIVE = 480;
  localparam int c_CNT_W    = 10;

  // 3-bit {R,G,B} colour constants
  localparam logic [2:0] c_BLACK = 3'b000;
  localparam logic [2:0] c_WHITE = 3'b111;
  localparam logic [2:0] c_RED   = 3'b100;

  // Direction of travel along one axis
  typedef enum logic [0:0] {
    DIR_POS = 1'b0,
    DIR_NEG = 1'b1
  } dir_e;

endpackage : vga_pkg
`default_nettype wire

// File: rtl/bounce_axis.sv
`default_nettype none
// ============================================================================
// Module   : bounce_axis
// Purpose  : One axis of the bouncing square: position plus direction,
//            stepped once per enabled frame tick, clamped at both edges.
// Revision : 1.0 - initial release
// ============================================================================
module bounce_axis
  import vga_pkg::*;
#(
  parameter int LIMIT = c_H_ACTIVE,
  parameter int SIZE  = 32,
  parameter int STEP  = 2,
  parameter int INIT  = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick_en,
  output logic [c_CNT_W-1:0] pos,
  output logic               bounce
);

  // One extra bit so position + size + step can never wrap
  localparam logic [c_CNT_W:0]   c_LIMIT = (c_CNT_W+1)'(LIMIT);
  localparam logic [c_CNT_W:0]   c_SIZE  = (c_CNT_W+1)'(SIZE);
  localparam logic [c_CNT_W:0]   c_STEP  = (c_CNT_W+1)'(STEP);
  localparam logic [c_CNT_W:0]   c_MAX   = c_LIMIT - c_SIZE;
  localparam logic [c_CNT_W-1:0] c_INIT  = c_CNT_W'(INIT);

  logic [c_CNT_W-1:0] pos_q, pos_d;
  dir_e               dir_q, dir_d;
  logic [c_CNT_W:0]   w_pos_ext;
  logic [c_CNT_W:0]   w_far_edge;

  assign w_pos_ext  = {1'b0, pos_q};
  assign w_far_edge = w_pos_ext + c_SIZE + c_STEP;

  // Next position/direction; bounce flags an edge hit on this tick
  always_comb begin
    pos_d  = pos_q;
    dir_d  = dir_q;
    bounce = 1'b0;
    if (tick_en) begin
      if (dir_q == DIR_POS) begin
        if (w_far_edge > c_LIMIT) begin
          pos_d  = c_MAX[c_CNT_W-1:0];
          dir_d  = DIR_NEG;
          bounce = 1'b1;
        end else begin
          pos_d = pos_q + c_STEP[c_CNT_W-1:0];
        end
      end else begin
        if (w_pos_ext < c_STEP) begin
          pos_d  = '0;
          dir_d  = DIR_POS;
          bounce = 1'b1;
        end else begin
          pos_d = pos_q - c_STEP[c_CNT_W-1:0];
        end
      end
    end
  end

  // Position and direction registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pos_q <= c_INIT;
      dir_q <= DIR_POS;
    end else begin
      pos_q <= pos_d;
      dir_q <= dir_d;
    end
  end

  assign pos = pos_q;

endmodule : bounce_axis
`default_nettype wire

// File: rtl/vga_bounce_box.sv
`default_nettype none
// ============================================================================
// Module   : vga_bounce_box
// Purpose  : Renders an edge-bouncing, colour-cycling square over a black
//            background with a white 1-pixel border; pixel and syncs are
//            registered together for one cycle of aligned latency.
// Revision : 1.0 - initial release
// ============================================================================
module vga_bounce_box
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = c_H_ACTIVE,
  parameter int V_ACTIVE = c_V_ACTIVE,
  parameter int BOX_SIZE = 32,
  parameter int STEP     = 2,
  parameter int INIT_X   = 100,
  parameter int INIT_Y   = 60
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               vga_h_sync_in,
  input  logic               vga_v_sync_in,
  input  logic               inDisplayArea,
  input  logic [c_CNT_W-1:0] CounterX,
  input  logic [c_CNT_W-1:0] CounterY,
  input  logic               pause,
  output logic               vga_h_sync,
  output logic               vga_v_sync,
  output logic [2:0]         pixel
);

  localparam logic [c_CNT_W-1:0] c_X_LAST = c_CNT_W'(H_ACTIVE - 1);
  localparam logic [c_CNT_W-1:0] c_Y_LAST = c_CNT_W'(V_ACTIVE - 1);
  localparam logic [c_CNT_W-1:0] c_Y_TICK = c_CNT_W'(V_ACTIVE);
  localparam logic [c_CNT_W:0]   c_SIZE   = (c_CNT_W+1)'(BOX_SIZE);

  logic               match_dly_q;
  logic [2:0]         colour_q, colour_d;
  logic [2:0]         pixel_q, pixel_d;
  logic               hsync_q, vsync_q;
  logic               w_match, w_tick;
  logic [c_CNT_W-1:0] box_x, box_y;
  logic               bounce_x, bounce_y;
  logic               w_in_box, w_on_border;

  // First line of vertical blanking, edge-detected so held counters tick once
  assign w_match = (CounterY == c_Y_TICK) && (CounterX == '0);
  assign w_tick  = w_match & ~match_dly_q & ~pause;

  bounce_axis #(
    .LIMIT (H_ACTIVE),
    .SIZE  (BOX_SIZE),
    .STEP  (STEP),
    .INIT  (INIT_X)
  ) u_axis_x (
    .clk     (clk),
    .reset   (reset),
    .tick_en (w_tick),
    .pos     (box_x),
    .bounce  (bounce_x)
  );

  bounce_axis #(
    .LIMIT (V_ACTIVE),
    .SIZE  (BOX_SIZE),
    .STEP  (STEP),
    .INIT  (INIT_Y)
  ) u_axis_y (
    .clk     (clk),
    .reset   (reset),
    .tick_en (w_tick),
    .pos     (box_y),
    .bounce  (bounce_y)
  );

  // Colour advances once per bouncing tick, skipping black
  always_comb begin
    colour_d = colour_q;
    if (w_tick && (bounce_x || bounce_y)) begin
      colour_d = (colour_q == 3'b111) ? 3'b001 : colour_q + 3'd1;
    end
  end

  assign w_in_box = (CounterX >= box_x) && ({1'b0, CounterX} < ({1'b0, box_x} + c_SIZE)) &&
                    (CounterY >= box_y) && ({1'b0, CounterY} < ({1'b0, box_y} + c_SIZE));
  assign w_on_border = (CounterX == '0) || (CounterX == c_X_LAST) ||
                       (CounterY == '0) || (CounterY == c_Y_LAST);

  // Pixel colour for the current counters; the box covers the border
  always_comb begin
    pixel_d = c_BLACK;
    if (!inDisplayArea) begin
      pixel_d = c_BLACK;
    end else if (w_in_box) begin
      pixel_d = colour_q;
    end else if (w_on_border) begin
      pixel_d = c_WHITE;
    end
  end

  // Output pipeline, tick edge detector and colour register
  always_ff @(posedge clk) begin
    if (reset) begin
      match_dly_q <= 1'b0;
      colour_q    <= c_RED;
      pixel_q     <= c_BLACK;
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
    end else begin
      match_dly_q <= w_match;
      colour_q    <= colour_d;
      pixel_q     <= pixel_d;
      hsync_q     <= vga_h_sync_in;
      vsync_q     <= vga_v_sync_in;
    end
  end

  assign pixel      = pixel_q;
  assign vga_h_sync = hsync_q;
  assign vga_v_sync = vsync_q;

endmodule : vga_bounce_box
`default_nettype wire

// File: doc/vga_bounce_box.md
Name: vga_bounce_box

Overview:
- Pixel-generation stage directly downstream of hvsync_generator.
- Consumes the generator's CounterX/CounterY/inDisplayArea and raw sync outputs.
- Renders a moving, edge-bouncing square over a black background with a white 1-pixel screen border. The square changes colour on every bounce.
- Drives the 3-bit VGA pixel and syncs, registered and aligned with one cycle of latency.

Parameters:
- H_ACTIVE, 640, visible pixels per line; width rules assume H_ACTIVE <= 1023.
- V_ACTIVE, 480, visible lines per frame; width rules assume V_ACTIVE <= 1023.
- BOX_SIZE, 32, square side in pixels; must be < V_ACTIVE.
- STEP, 2, pixels moved per frame on each axis; must be >= 1 and <= BOX_SIZE.
- INIT_X, 100, reset X of the square's top-left corner; must be <= H_ACTIVE-BOX_SIZE.
- INIT_Y, 60, reset Y of the square's top-left corner; must be <= V_ACTIVE-BOX_SIZE.

Ports:
- clk  input  1  pixel clock, the same clock as hvsync_generator.
- reset  input  1  synchronous, active-high reset.
- vga_h_sync_in  input  1  raw horizontal sync from hvsync_generator.
- vga_v_sync_in  input  1  raw vertical sync from hvsync_generator.
- inDisplayArea  input  1  high while CounterX/CounterY address a visible pixel.
- CounterX  input  10  current horizontal position.
- CounterY  input  10  current vertical position.
- pause  input  1  when high, frame updates are suppressed and position, direction and colour hold.
- vga_h_sync  output  1  vga_h_sync_in delayed 1 cycle.
- vga_v_sync  output  1  vga_v_sync_in delayed 1 cycle.
- pixel  output  3  {R,G,B} for the pixel presented on the previous cycle.

Behaviour:
- Reset (synchronous, on clk rising edge with reset=1):
  - box_x=INIT_X, box_y=INIT_Y; dir_x=dir_y=+ (right/down); colour=3'b100.
  - pixel=3'b000; vga_h_sync=vga_v_sync=1'b1; match_d=0.
- Reset asserted mid-frame restores these values on the next edge. The first frame tick after reset release uses the reset values.
- Frame tick:
  - match = (CounterY==V_ACTIVE && CounterX==0); match_d is match registered.
  - tick = match & ~match_d, giving exactly one cycle per frame even if the counters hold.
  - Updates apply on the tick cycle only when pause=0.
- Axis update, X shown; Y is identical with V_ACTIVE:
  - dir +: if box_x+BOX_SIZE+STEP > H_ACTIVE, then box_x <= H_ACTIVE-BOX_SIZE, dir_x <= -, bounce_x=1; else box_x <= box_x+STEP.
  - dir -: if box_x < STEP, then box_x <= 0, dir_x <= +, bounce_x=1; else box_x <= box_x-STEP.
  - Arithmetic is 11-bit unsigned so the sum cannot overflow. Positions are stored as 10 bits.
- Colour:
  - If bounce_x|bounce_y on a tick, colour <= colour+1, wrapping 3'b111 -> 3'b001 (never 0).
  - A simultaneous X and Y bounce (corner hit) increments once.
- Pixel pipeline, with all terms evaluated on the current inputs and registered:
  - if !inDisplayArea -> pixel <= 3'b000;
  - else if box_x <= CounterX < box_x+BOX_SIZE and box_y <= CounterY < box_y+BOX_SIZE -> pixel <= colour;
  - else if CounterX==0 || CounterX==H_ACTIVE-1 || CounterY==0 || CounterY==V_ACTIVE-1 -> pixel <= 3'b111;
  - else pixel <= 3'b000.
  - The box has priority over the border.
- Latency and tearing:
  - Pixel and syncs have 1 cycle of latency with identical alignment.
  - Because updates occur during vertical blanking, no frame shows a partially moved box.
- Sync pass-through is unaffected by pause; its reset value is 1 (idle level of active-low syncs).

Decomposition:
- Package vga_pkg holds:
  - H_ACTIVE/V_ACTIVE defaults and the counter width constant (10).
  - Colour constants: BLACK=3'b000, WHITE=3'b111, RED=3'b100.
  - Direction enum: DIR_POS / DIR_NEG.
- Sub-module bounce_axis:
  - Parameters: LIMIT, SIZE, STEP, INIT.
  - Inputs: clk, reset, tick_en. Outputs: pos[9:0], bounce.
  - Instantiated twice (X, Y); the top level holds the tick detector, colour register and pixel pipeline.

Test Plan:
- Reset, then 2 idle cycles -> pixel=000, vga_h_sync=vga_v_sync=1, box at (100,60), colour=100.
- Drive counters to (0,480) for 3 consecutive cycles -> exactly one update; box moves to (102,62).
- After the update, drive (102,62) with inDisplayArea=1 -> pixel=100 on the next cycle. Drive (101,62) -> 000. Drive (0,200) -> 111. Drive (700,10) with inDisplayArea=0 -> 000.
- INIT_X=606: first tick -> x=608; second tick -> x=608, dir_x=-, colour=101; third tick -> x=606.
- INIT_X=606, INIT_Y=446 (corner): second tick bounces both axes -> colour increments once (100 -> 101), not twice.
- Scenarios combining pause, wrap, reset and sync alignment:
  - pause=1 across 2 ticks -> position and colour unchanged.
  - Colour at 111 plus a bounce -> colour=001.
  - Reset during tick cycle -> reset values win.
  - A sync toggle on the input appears on the output exactly 1 cycle later.
